// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the seven-segment scan capture block.
//   SEG7_DIGITS      number of multiplexed digits on the bus
//   SEG7_GLYPH_0..F  active-low segment patterns ([6:0] = g..a) for hex 0..F
//   cap_state_t      capture FSM states
//   seg7_decode()    glyph -> {ok, nibble}; illegal glyphs give 5'b0_0000
package seg7_pkg;

  localparam int SEG7_DIGITS = 8;

  localparam logic [6:0] SEG7_GLYPH_0 = 7'h40;
  localparam logic [6:0] SEG7_GLYPH_1 = 7'h79;
  localparam logic [6:0] SEG7_GLYPH_2 = 7'h24;
  localparam logic [6:0] SEG7_GLYPH_3 = 7'h30;
  localparam logic [6:0] SEG7_GLYPH_4 = 7'h19;
  localparam logic [6:0] SEG7_GLYPH_5 = 7'h12;
  localparam logic [6:0] SEG7_GLYPH_6 = 7'h02;
  localparam logic [6:0] SEG7_GLYPH_7 = 7'h78;
  localparam logic [6:0] SEG7_GLYPH_8 = 7'h00;
  localparam logic [6:0] SEG7_GLYPH_9 = 7'h10;
  localparam logic [6:0] SEG7_GLYPH_A = 7'h08;
  localparam logic [6:0] SEG7_GLYPH_B = 7'h03;
  localparam logic [6:0] SEG7_GLYPH_C = 7'h46;
  localparam logic [6:0] SEG7_GLYPH_D = 7'h21;
  localparam logic [6:0] SEG7_GLYPH_E = 7'h06;
  localparam logic [6:0] SEG7_GLYPH_F = 7'h0E;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } cap_state_t;

  function automatic logic [4:0] seg7_decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      SEG7_GLYPH_0: r = {1'b1, 4'h0};
      SEG7_GLYPH_1: r = {1'b1, 4'h1};
      SEG7_GLYPH_2: r = {1'b1, 4'h2};
      SEG7_GLYPH_3: r = {1'b1, 4'h3};
      SEG7_GLYPH_4: r = {1'b1, 4'h4};
      SEG7_GLYPH_5: r = {1'b1, 4'h5};
      SEG7_GLYPH_6: r = {1'b1, 4'h6};
      SEG7_GLYPH_7: r = {1'b1, 4'h7};
      SEG7_GLYPH_8: r = {1'b1, 4'h8};
      SEG7_GLYPH_9: r = {1'b1, 4'h9};
      SEG7_GLYPH_A: r = {1'b1, 4'hA};
      SEG7_GLYPH_B: r = {1'b1, 4'hB};
      SEG7_GLYPH_C: r = {1'b1, 4'hC};
      SEG7_GLYPH_D: r = {1'b1, 4'hD};
      SEG7_GLYPH_E: r = {1'b1, 4'hE};
      SEG7_GLYPH_F: r = {1'b1, 4'hF};
      default:      r = 5'b0_0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// seg7_glyph_decode: combinational seven-segment glyph to hex nibble decoder.
//   glyph   in  7  active-low segments g..a (decimal point excluded)
//   nibble  out 4  decoded hex value, 0 when the glyph is not a hex digit
//   ok      out 1  glyph matched one of the sixteen hex patterns
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] glyph,
  output logic [3:0] nibble,
  output logic       ok
);

  logic [4:0] dec;

  assign dec    = seg7_decode(glyph);
  assign ok     = dec[4];
  assign nibble = dec[3:0];

endmodule

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: passive monitor that rebuilds the 8-digit frame shown on
// a multiplexed active-low seven-segment bus.
//   CLK100MHZ      in   system clock
//   CPU_RESETN     in   async active-low reset
//   i_sel[7:0]     in   digit select, active-low (bit k low = digit k)
//   i_seg[7:0]     in   segments, active-low ([6:0] = g..a, [7] = dp)
//   o_frame_raw    out  raw segment byte of digit k at [8k+7:8k]
//   o_frame_hex    out  decoded nibble of digit k at [4k+3:4k]
//   o_hex_ok       out  bit k set when digit k held a legal hex glyph
//   o_frame_valid  out  one-cycle pulse, frame outputs updated
//   o_sel_err      out  one-cycle pulse per cycle with a multi-hot select
//   o_timeout      out  one-cycle pulse, partial frame discarded
// Build option: define SEG7_CAPTURE_DECODE_EN to build the glyph decoders;
// without it o_frame_hex and o_hex_ok are constant 0.
//
// state  | meaning
// IDLE   | select blanked (all ones) or not yet one-hot
// SETTLE | one-hot select seen, counting consecutive stable cycles
// HOLD   | digit sampled, waiting for the select to move
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic [7:0]  i_sel,
  input  logic [7:0]  i_seg,
  output logic [63:0] o_frame_raw,
  output logic [31:0] o_frame_hex,
  output logic [7:0]  o_hex_ok,
  output logic        o_frame_valid,
  output logic        o_sel_err,
  output logic        o_timeout
);

  localparam logic [8:0]  SETTLE_LEN  = 9'(SETTLE_CYCLES);
  localparam logic [31:0] TIMEOUT_LEN = 32'(TIMEOUT_CYCLES);

  logic [7:0]  sel_q, seg_q;
  cap_state_t  state;
  logic [7:0]  cur_sel;
  logic [7:0]  settle_cnt;
  logic [7:0]  mask;
  logic [63:0] shadow;
  logic [31:0] idle_cnt;

  logic [7:0]  sel_act;
  logic        multi_hot, one_hot, advance, sample, frame_done;
  logic [8:0]  run_len;
  logic [31:0] dec_hex;
  logic [7:0]  dec_ok;

  // advance: the select is one-hot and not simply parked on the digit
  // already sampled, so the stable-run count moves (or restarts at 1).
  always_comb begin
    sel_act    = ~sel_q;
    multi_hot  = (sel_act & (sel_act - 8'd1)) != 8'd0;
    one_hot    = (sel_act != 8'd0) && !multi_hot;
    advance    = one_hot && !(state == HOLD && sel_q == cur_sel);
    run_len    = (state == SETTLE && sel_q == cur_sel) ?
                 {1'b0, settle_cnt} + 9'd1 : 9'd1;
    sample     = advance && (run_len >= SETTLE_LEN);
    frame_done = (mask == 8'hFF);
  end

`ifdef SEG7_CAPTURE_DECODE_EN
  for (genvar k = 0; k < SEG7_DIGITS; k++) begin : g_dec
    seg7_glyph_decode u_dec (
      .glyph  (shadow[8*k +: 7]),
      .nibble (dec_hex[4*k +: 4]),
      .ok     (dec_ok[k])
    );
  end
`else
  assign dec_hex = '0;
  assign dec_ok  = '0;
`endif

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sel_q         <= 8'hFF;
      seg_q         <= 8'h00;
      state         <= IDLE;
      cur_sel       <= 8'hFF;
      settle_cnt    <= 8'd0;
      mask          <= 8'd0;
      shadow        <= 64'd0;
      idle_cnt      <= 32'd0;
      o_frame_raw   <= 64'd0;
      o_frame_hex   <= 32'd0;
      o_hex_ok      <= 8'd0;
      o_frame_valid <= 1'b0;
      o_sel_err     <= 1'b0;
      o_timeout     <= 1'b0;
    end else begin
      sel_q         <= i_sel;
      seg_q         <= i_seg;
      o_frame_valid <= 1'b0;
      o_sel_err     <= 1'b0;
      o_timeout     <= 1'b0;

      if (multi_hot) begin
        state      <= IDLE;
        cur_sel    <= 8'hFF;
        settle_cnt <= 8'd0;
        o_sel_err  <= 1'b1;
      end else if (!one_hot) begin
        state      <= IDLE;
        cur_sel    <= 8'hFF;
        settle_cnt <= 8'd0;
      end else if (advance) begin
        cur_sel    <= sel_q;
        settle_cnt <= run_len[7:0];
        state      <= sample ? HOLD : SETTLE;
      end

      // Publish reads the shadow before any same-edge sample overwrites it.
      if (frame_done) begin
        o_frame_raw   <= shadow;
        o_frame_hex   <= dec_hex;
        o_hex_ok      <= dec_ok;
        o_frame_valid <= 1'b1;
      end

      if (multi_hot) begin
        mask     <= 8'd0;
        shadow   <= 64'd0;
        idle_cnt <= 32'd0;
      end else if (sample) begin
        mask     <= (frame_done ? 8'd0 : mask) | sel_act;
        idle_cnt <= 32'd0;
        for (int k = 0; k < SEG7_DIGITS; k++) begin
          if (sel_act[k]) shadow[8*k +: 8] <= seg_q;
        end
      end else if (frame_done) begin
        mask     <= 8'd0;
        idle_cnt <= 32'd0;
      end else if (mask != 8'd0) begin
        if (idle_cnt + 32'd1 >= TIMEOUT_LEN) begin
          mask      <= 8'd0;
          idle_cnt  <= 32'd0;
          o_timeout <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + 32'd1;
        end
      end else begin
        idle_cnt <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb_seg7_scan_capture: directed and randomized scans of the seven-segment bus
// checked against a visit-level reference model of the capture rules.
module tb_seg7_scan_capture;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 400;

  logic        clk_sys = 1'b0;
  logic        rst_n   = 1'b0;
  logic [7:0]  sel     = 8'hFF;
  logic [7:0]  seg     = 8'h00;
  logic [63:0] frame_raw;
  logic [31:0] frame_hex;
  logic [7:0]  hex_ok;
  logic        frame_valid, sel_err, timeout;

  always #5 clk_sys = ~clk_sys;

  seg7_scan_capture #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .CLK100MHZ     (clk_sys),
    .CPU_RESETN    (rst_n),
    .i_sel         (sel),
    .i_seg         (seg),
    .o_frame_raw   (frame_raw),
    .o_frame_hex   (frame_hex),
    .o_hex_ok      (hex_ok),
    .o_frame_valid (frame_valid),
    .o_sel_err     (sel_err),
    .o_timeout     (timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // pulse counters observed on the DUT
  int obs_fv = 0, obs_err = 0, obs_to = 0;
  always @(negedge clk_sys) begin
    if (frame_valid) obs_fv++;
    if (sel_err)     obs_err++;
    if (timeout)     obs_to++;
  end

  // reference model state
  logic [6:0]  glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [7:0]  m_mask   = 8'h00;
  logic [63:0] m_shadow = 64'd0;
  logic [63:0] m_raw    = 64'd0;
  logic [31:0] m_hex    = 32'd0;
  logic [7:0]  m_ok     = 8'h00;
  int          m_fv = 0, m_err = 0, m_to = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int glyph_value(input logic [6:0] g);
    for (int i = 0; i < 16; i++) if (glyph[i] == g) return i;
    return -1;
  endfunction

  function automatic int count_low(input logic [7:0] s);
    int n = 0;
    for (int i = 0; i < 8; i++) if (!s[i]) n++;
    return n;
  endfunction

  function automatic logic [7:0] dig_sel(input int k);
    logic [7:0] one = 8'h01;
    return ~(one << k);
  endfunction

  task automatic model_publish();
    int v;
    m_raw = m_shadow;
    m_hex = 32'd0;
    m_ok  = 8'h00;
`ifdef SEG7_CAPTURE_DECODE_EN
    for (int k = 0; k < 8; k++) begin
      v = glyph_value(m_shadow[8*k +: 7]);
      if (v >= 0) begin
        m_hex[4*k +: 4] = 4'(v);
        m_ok[k] = 1'b1;
      end
    end
`endif
    m_fv++;
    m_mask = 8'h00;
  endtask

  task automatic model_visit(input logic [7:0] s, input logic [7:0] d, input int hold);
    int n = count_low(s);
    if (n > 1) begin
      m_err += hold;
      m_mask = 8'h00;
      m_shadow = 64'd0;
    end else if (n == 1 && hold >= SETTLE) begin
      for (int k = 0; k < 8; k++) begin
        if (!s[k]) begin
          m_shadow[8*k +: 8] = d;
          m_mask[k] = 1'b1;
        end
      end
      if (m_mask == 8'hFF) model_publish();
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
    #1;
  endtask

  task automatic visit(input logic [7:0] s, input logic [7:0] d, input int hold, input int gap);
    sel = s;
    seg = d;
    tick(hold);
    model_visit(s, d, hold);
    if (gap > 0) begin
      sel = 8'hFF;
      seg = 8'($urandom);
      tick(gap);
    end
  endtask

  // blanking long enough to expire the idle timer when a partial frame exists
  task automatic stall(input int cycles);
    sel = 8'hFF;
    tick(cycles);
    if (cycles > TIMEOUT + 20 && m_mask != 8'h00) begin
      m_to++;
      m_mask = 8'h00;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".fv_cnt"},  64'(obs_fv),  64'(m_fv));
    chk({tag, ".err_cnt"}, 64'(obs_err), 64'(m_err));
    chk({tag, ".to_cnt"},  64'(obs_to),  64'(m_to));
    chk({tag, ".raw"},     frame_raw,    m_raw);
    chk({tag, ".hex"},     64'(frame_hex), 64'(m_hex));
    chk({tag, ".ok"},      64'(hex_ok),  64'(m_ok));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".raw0"},   frame_raw,        64'd0);
    chk({tag, ".hex0"},   64'(frame_hex),   64'd0);
    chk({tag, ".ok0"},    64'(hex_ok),      64'd0);
    chk({tag, ".pulse0"}, 64'({frame_valid, sel_err, timeout}), 64'd0);
  endtask

  logic [63:0] exp_raw;
  logic [31:0] exp_hex;
  logic [7:0]  exp_ok;
  int          rk;
  logic [7:0]  rs, rd;

  initial begin
    tick(3);
    check_zero("reset");
    rst_n = 1'b1;
    tick(2);
    check_state("reset");

    // text frame: digit k shows 8-k, 10 cycles per digit, back to back
    for (int k = 0; k < 8; k++) visit(dig_sel(k), {1'b1, glyph[8-k]}, 10, 0);
    stall(6);
    check_state("text");
`ifdef SEG7_CAPTURE_DECODE_EN
    exp_hex = 32'h12345678; exp_ok = 8'hFF;
`else
    exp_hex = 32'h0; exp_ok = 8'h00;
`endif
    chk("text.hex_const", 64'(frame_hex), 64'(exp_hex));
    chk("text.ok_const",  64'(hex_ok),    64'(exp_ok));

    // graph pattern: FF on odd digits, 00 on even digits, scanned 7..0
    for (int k = 7; k >= 0; k--) visit(dig_sel(k), (k % 2 == 1) ? 8'hFF : 8'h00, 8, 1);
    stall(6);
    check_state("graph");
    exp_raw = 64'hFF00FF00FF00FF00;
`ifdef SEG7_CAPTURE_DECODE_EN
    exp_hex = 32'h08080808; exp_ok = 8'h55;
`else
    exp_hex = 32'h0; exp_ok = 8'h00;
`endif
    chk("graph.raw_const", frame_raw, exp_raw);
    chk("graph.hex_const", 64'(frame_hex), 64'(exp_hex));
    chk("graph.ok_const",  64'(hex_ok), 64'(exp_ok));

    // glitch: 3-cycle select on digit 2 must not count; exactly SETTLE does
    visit(dig_sel(2), 8'hA5, SETTLE - 1, 4);
    for (int k = 0; k < 8; k++) if (k != 2) visit(dig_sel(k), 8'(8'h10 + k), 6, 3);
    stall(4);
    check_state("glitch_short");
    visit(dig_sel(2), 8'h5A, SETTLE, 6);
    check_state("glitch_exact");

    // multi-hot after 5 digits, then a full fresh scan
    for (int k = 0; k < 5; k++) visit(dig_sel(k), 8'(8'hC0 + k), 6, 2);
    visit(8'hFC, 8'h77, 1, 4);
    check_state("multihot_err");
    for (int k = 0; k < 8; k++) visit(dig_sel(k), {1'b0, glyph[k + 8]}, 6, 2);
    stall(6);
    check_state("multihot_scan");

    // half-timeout gap keeps the partial frame
    for (int k = 0; k < 4; k++) visit(dig_sel(k), 8'(8'h20 + k), 6, 2);
    stall(TIMEOUT / 2);
    for (int k = 4; k < 8; k++) visit(dig_sel(k), 8'(8'h20 + k), 6, 2);
    stall(6);
    check_state("no_timeout");

    // stall past the timeout discards the partial frame
    for (int k = 0; k < 4; k++) visit(dig_sel(k), 8'(8'h30 + k), 6, 2);
    stall(TIMEOUT + 50);
    check_state("stall");
    for (int k = 4; k < 8; k++) visit(dig_sel(k), 8'(8'h30 + k), 6, 2);
    stall(6);
    check_state("stall_rest");

    // randomized visits
    for (int i = 0; i < 160; i++) begin
      rk = int'($urandom_range(0, 7));
      rd = ($urandom_range(0, 1) == 1) ? {1'($urandom), glyph[$urandom_range(0, 15)]} : 8'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        rs = dig_sel(rk) & dig_sel((rk + int'($urandom_range(1, 7))) % 8);
        visit(rs, rd, 1, int'($urandom_range(3, 6)));
      end else begin
        visit(dig_sel(rk), rd, int'($urandom_range(1, 10)), int'($urandom_range(3, 6)));
      end
      if (i % 16 == 15) check_state("random");
    end
    stall(6);
    check_state("random_end");

    // reset in the middle of a scan
    for (int k = 0; k < 3; k++) visit(dig_sel(k), 8'(8'h40 + k), 6, 2);
    sel = dig_sel(3);
    tick(2);
    rst_n = 1'b0;
    #2;
    check_zero("midreset");
    m_mask = 8'h00; m_shadow = 64'd0; m_raw = 64'd0; m_hex = 32'd0; m_ok = 8'h00;
    sel = 8'hFF;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    for (int k = 2; k < 8; k++) visit(dig_sel(k), 8'(8'h50 + k), 6, 2);
    stall(6);
    check_state("midreset_partial");
    for (int k = 0; k < 2; k++) visit(dig_sel(k), 8'(8'h50 + k), 6, 2);
    stall(6);
    check_state("midreset_full");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
